// File: rtl/sd4_otf_if.sv
// Handshake bundle between the SD adder, the on-the-fly converter and the binary back end.
interface sd4_otf_if #(
    parameter int NUM_DIGITS = 8,
    parameter int RADIX_BITS = 3
);
    localparam int OUT_W = 2*NUM_DIGITS + 3;

    logic                             in_valid;
    logic                             in_ready;
    logic [NUM_DIGITS*RADIX_BITS-1:0] in_digits;
    logic [RADIX_BITS-1:0]            in_carry;
    logic                             out_valid;
    logic                             out_ready;
    logic signed [OUT_W-1:0]          out_value;
    logic                             out_err;

    modport master (
        output in_valid, in_digits, in_carry, out_ready,
        input  in_ready, out_valid, out_value, out_err
    );

    modport slave (
        input  in_valid, in_digits, in_carry, out_ready,
        output in_ready, out_valid, out_value, out_err
    );
endinterface

// File: rtl/sd4_otf_converter.sv
// Radix-4 signed-digit to two's complement converter, MSD first, one digit per cycle,
// using the Q/QM on-the-fly scheme so no carry-propagate adder is needed.
module sd4_otf_converter #(
    parameter int NUM_DIGITS = 8,
    parameter int RADIX_BITS = 3
) (
    input logic      clk,
    input logic      rst_n,
    sd4_otf_if.slave bus
);
    localparam int OUT_W = 2*NUM_DIGITS + 3;
    localparam int SH_W  = (NUM_DIGITS+1)*RADIX_BITS;
    localparam int CNT_W = $clog2(NUM_DIGITS+1);
    localparam logic [RADIX_BITS-1:0] ILLEGAL = {1'b1, {(RADIX_BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [SH_W-1:0]         shreg;
    logic signed [OUT_W-1:0] q, qm, q_nx, qm_nx, value;
    logic                    err;
    logic [RADIX_BITS-1:0]   dig_raw;
    logic signed [RADIX_BITS-1:0] dig;
    logic                    dig_bad;
    logic                    accept;

    // Low two bits appended to Q: d for d>=0, 4+d (borrow taken from QM) for d<0.
    function automatic logic [1:0] q_low(input logic signed [RADIX_BITS-1:0] d);
        int v;
        v = (d < 0) ? int'(d) + 4 : int'(d);
        return v[1:0];
    endfunction

    // Low two bits appended to QM: d-1 for d>0, 3+d for d<=0.
    function automatic logic [1:0] qm_low(input logic signed [RADIX_BITS-1:0] d);
        int v;
        v = (d > 0) ? int'(d) - 1 : int'(d) + 3;
        return v[1:0];
    endfunction

    assign accept  = (state == IDLE) && bus.in_valid;
    assign dig_raw = shreg[SH_W-1 -: RADIX_BITS];
    assign dig_bad = (dig_raw == ILLEGAL);
    assign dig     = dig_bad ? '0 : $signed(dig_raw);

    always_comb begin
        q_nx  = (dig >= 0) ? {q[OUT_W-3:0], q_low(dig)} : {qm[OUT_W-3:0], q_low(dig)};
        qm_nx = (dig > 0) ? {q[OUT_W-3:0], qm_low(dig)} : {qm[OUT_W-3:0], qm_low(dig)};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = CONV;
            CONV:    if (cnt == '0)     state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Digit shift register carries only data; it is reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept)             shreg <= {bus.in_carry, bus.in_digits};
        else if (state == CONV) shreg <= shreg << RADIX_BITS;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            qm    <= '1;
            cnt   <= '0;
            value <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            q   <= '0;
            qm  <= '1;
            cnt <= CNT_W'(NUM_DIGITS);
            err <= 1'b0;
        end else if (state == CONV) begin
            q   <= q_nx;
            qm  <= qm_nx;
            cnt <= cnt - 1'b1;
            if (dig_bad)     err   <= 1'b1;
            if (cnt == '0)   value <= q_nx;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_value = value;
    assign bus.out_err   = err;
endmodule
